// File: rtl/wb_stage_buffered.sv
// rtl/wb_stage_buffered.sv - buffered write-back stage: in-order retire, load extraction, registered RF write port
module wb_stage_buffered #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      mem_r_en,
  input  logic                      wb_en,
  input  logic [DEST_W-1:0]         dest,
  input  logic [1:0]                ld_mode,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_rvalid,
  output logic                      wb_en_out,
  output logic [DEST_W-1:0]         dest_out,
  output logic [DATA_W-1:0]         wb_value,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic                      proto_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [DATA_W-1:0] e_alu  [DEPTH];
  logic              e_ld   [DEPTH];
  logic              e_wb   [DEPTH];
  logic [DEST_W-1:0] e_dest [DEPTH];
  logic [1:0]        e_mode [DEPTH];

  logic [PTR_W-1:0]  head, tail;
  logic              empty, push, retire, head_ld, stray;
  logic [31:0]       word;
  logic [1:0]        off;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_value, sel_value;

  assign empty    = (occupancy == '0);
  assign in_ready = (occupancy != OCC_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign head_ld  = e_ld[head];
  assign retire   = !empty && (!head_ld || mem_rvalid);
  // A response with no load waiting at the head has nowhere to go.
  assign stray    = mem_rvalid && (empty || !head_ld);

  always_comb begin
    word    = mem_rdata[31:0];
    off     = e_alu[head][1:0];
    ld_byte = word[7:0];
    case (off)
      2'd1:    ld_byte = word[15:8];
      2'd2:    ld_byte = word[23:16];
      2'd3:    ld_byte = word[31:24];
      default: ld_byte = word[7:0];
    endcase
    ld_half = off[1] ? word[31:16] : word[15:0];
    case (e_mode[head])
      2'b00:   ld_value = mem_rdata;
      2'b01:   ld_value = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      2'b10:   ld_value = {{(DATA_W-8){1'b0}}, ld_byte};
      default: ld_value = {{(DATA_W-16){ld_half[15]}}, ld_half};
    endcase
    sel_value = head_ld ? ld_value : e_alu[head];
  end

  // Entry payload needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      e_alu[tail]  <= alu_result;
      e_ld[tail]   <= mem_r_en;
      e_wb[tail]   <= wb_en;
      e_dest[tail] <= dest;
      e_mode[tail] <= ld_mode;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      wb_en_out <= 1'b0;
      dest_out  <= '0;
      wb_value  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (push)
        tail <= tail + PTR_W'(1);
      if (retire)
        head <= head + PTR_W'(1);
      case ({push, retire})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
      wb_en_out <= retire && e_wb[head];
      if (retire) begin
        dest_out <= e_dest[head];
        wb_value <= sel_value;
      end
      if (stray)
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_stage_buffered.sv
// tb/tb_wb_stage_buffered.sv - scoreboard bench for wb_stage_buffered
module tb_wb_stage_buffered;
  localparam int DATA_W = 32;
  localparam int DEST_W = 4;
  localparam int DEPTH  = 2;
  localparam int OCC_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] alu_result = '0;
  logic              mem_r_en = 1'b0;
  logic              wb_en = 1'b0;
  logic [DEST_W-1:0] dest = '0;
  logic [1:0]        ld_mode = '0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_rvalid = 1'b0;
  logic              wb_en_out;
  logic [DEST_W-1:0] dest_out;
  logic [DATA_W-1:0] wb_value;
  logic [OCC_W-1:0]  occupancy;
  logic              proto_err;

  always #5 clk = ~clk;

  wb_stage_buffered #(.DATA_W(DATA_W), .DEST_W(DEST_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .mem_r_en(mem_r_en), .wb_en(wb_en), .dest(dest),
    .ld_mode(ld_mode), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .wb_en_out(wb_en_out), .dest_out(dest_out), .wb_value(wb_value),
    .occupancy(occupancy), .proto_err(proto_err)
  );

  typedef struct {
    logic              ld;
    logic [DEST_W-1:0] dest;
    logic [31:0]       rdata;
  } ment_t;

  typedef struct {
    logic [DEST_W-1:0] dest;
    logic [31:0]       val;
  } exp_t;

  ment_t mq[$];
  exp_t  eq[$];
  logic  m_perr = 1'b0;
  int    n_checks = 0;
  int    n_err = 0;
  logic  acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_value(input logic [31:0] alu, input logic ld,
                                            input logic [1:0] mode, input logic [31:0] rdata);
    int unsigned b, h, off;
    if (!ld) return alu;
    off = alu % 4;
    b = (rdata >> (8 * off)) % 256;
    h = (rdata >> (16 * (off / 2))) % 65536;
    case (mode)
      2'd0:    return rdata;
      2'd1:    return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
      2'd2:    return 32'(b);
      default: return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
    endcase
  endfunction

  task automatic step(input logic v, input logic [31:0] alu, input logic ld, input logic we,
                      input logic [DEST_W-1:0] d, input logic [1:0] mode,
                      input logic [31:0] rdata, input logic rv, output logic accepted);
    logic  retire;
    ment_t e;
    exp_t  x;
    @(negedge clk); #1;
    chk("occupancy", occupancy, mq.size());
    chk("in_ready", in_ready, mq.size() != DEPTH);
    in_valid = v; alu_result = alu; mem_r_en = ld; wb_en = we; dest = d;
    ld_mode = mode; mem_rvalid = rv;
    mem_rdata = (mq.size() > 0 && mq[0].ld) ? mq[0].rdata : $urandom;
    accepted = v && (mq.size() != DEPTH);
    retire = (mq.size() > 0) && (!mq[0].ld || rv);
    if (rv && (mq.size() == 0 || !mq[0].ld)) m_perr = 1'b1;
    if (retire) void'(mq.pop_front());
    if (accepted) begin
      e.ld = ld; e.dest = d; e.rdata = rdata;
      mq.push_back(e);
      if (we) begin
        x.dest = d; x.val = ref_value(alu, ld, mode, rdata);
        eq.push_back(x);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic idle(input logic rv);
    logic a;
    step(1'b0, 32'd0, 1'b0, 1'b0, '0, 2'd0, 32'd0, rv, a);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && mq.size() > 0; k++)
      idle(mq[0].ld);
    idle(1'b0);
    chk("drain_all_written", eq.size(), 0);
  endtask

  task automatic apply_reset();
    #2;
    rst = 1'b0;
    in_valid = 1'b0; mem_rvalid = 1'b0;
    mq.delete(); eq.delete(); m_perr = 1'b0;
    #1;
    chk("rst_wb_en_out", wb_en_out, 0);
    chk("rst_dest_out", dest_out, 0);
    chk("rst_wb_value", wb_value, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_proto_err", proto_err, 0);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    chk("proto_err", proto_err, m_perr);
    if (wb_en_out === 1'b1) begin
      if (eq.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL spurious_write: got write dest %0d value 0x%0h expected no write", dest_out, wb_value);
      end else begin
        x = eq.pop_front();
        chk("wb_dest", dest_out, x.dest);
        chk("wb_value", wb_value, x.val);
      end
    end
  end

  logic [1:0]  sw_mode [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
  logic [1:0]  sw_off  [4] = '{2'd3, 2'd2, 2'd2, 2'd0};
  logic [31:0] sw_exp  [4] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01};

  initial begin
    int pushed;
    logic rv;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("init_wb_en_out", wb_en_out, 0);
    chk("init_occupancy", occupancy, 0);
    chk("init_in_ready", in_ready, 1);

    // Single non-load: written one edge after the push edge, for one cycle only.
    step(1'b1, 32'h0000_1234, 1'b0, 1'b1, 4'd5, 2'd0, 32'd0, 1'b0, acc);
    idle(1'b0);
    chk("nl_wb_en_out", wb_en_out, 1);
    chk("nl_dest_out", dest_out, 5);
    chk("nl_wb_value", wb_value, 32'h1234);
    idle(1'b0);
    chk("nl_one_cycle", wb_en_out, 0);

    // Stalled load blocks the younger ALU op.
    step(1'b1, 32'h0000_0100, 1'b1, 1'b1, 4'd3, 2'd0, 32'hDEAD_BEEF, 1'b0, acc);
    step(1'b1, 32'h0000_0444, 1'b0, 1'b1, 4'd4, 2'd0, 32'd0, 1'b0, acc);
    for (int k = 0; k < 3; k++) begin
      idle(1'b0);
      chk("stall_wb_en_out", wb_en_out, 0);
    end
    chk("stall_occupancy", occupancy, 2);
    chk("stall_in_ready", in_ready, 0);
    idle(1'b1);
    chk("ld_dest", dest_out, 3);
    chk("ld_value", wb_value, 32'hDEAD_BEEF);
    idle(1'b0);
    chk("after_ld_dest", dest_out, 4);
    chk("after_ld_value", wb_value, 32'h444);
    idle(1'b0);

    // Sub-word extraction.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, ($urandom & 32'hFFFF_FFFC) | 32'(sw_off[i]), 1'b1, 1'b1, 4'(i + 8),
           sw_mode[i], 32'h80FF_7F01, 1'b0, acc);
      idle(1'b1);
      chk("subword_wb_en", wb_en_out, 1);
      chk("subword_value", wb_value, sw_exp[i]);
    end
    idle(1'b0);

    // Back-to-back stream with in_valid held.
    pushed = 0;
    for (int k = 0; k < 30 && pushed < 6; k++) begin
      step(1'b1, 32'h0000_0100 + 32'(pushed), 1'b0, 1'b1, 4'(pushed + 1), 2'd0, 32'd0, 1'b0, acc);
      if (acc) pushed++;
    end
    drain();

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      rv = (mq.size() > 0 && mq[0].ld) ? ($urandom_range(0, 99) < 40) : 1'b0;
      step($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) < 8, 4'($urandom), 2'($urandom), $urandom, rv, acc);
    end
    drain();

    // Reset with two loads held.
    step(1'b1, 32'h0000_0200, 1'b1, 1'b1, 4'd1, 2'd0, 32'h1111_1111, 1'b0, acc);
    step(1'b1, 32'h0000_0204, 1'b1, 1'b1, 4'd2, 2'd0, 32'h2222_2222, 1'b0, acc);
    chk("held_occupancy", occupancy, 2);
    apply_reset();

    // Stray response while empty.
    idle(1'b1);
    chk("perr_set", proto_err, 1);
    for (int k = 0; k < 4; k++)
      step(1'b1, $urandom, 1'b0, 1'b1, 4'($urandom), 2'd0, 32'd0, 1'b0, acc);
    drain();
    chk("perr_sticky", proto_err, 1);
    apply_reset();
    idle(1'b0);
    chk("perr_cleared", proto_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
